// File: rtl/rom_fetch_arbiter.sv
// Shares one single-port instruction ROM between the fetch port (F) and the
// debug/loader port (D). F has fixed priority; a starvation counter forces a D grant.
module rom_fetch_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  f_req_valid,
   input  logic [ADDR_WIDTH-1:0] f_req_addr,
   output logic                  f_req_ready,
   output logic                  f_rsp_valid,
   output logic [DATA_WIDTH-1:0] f_rsp_data,
   input  logic                  f_rsp_ready,
   input  logic                  d_req_valid,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   output logic                  d_req_ready,
   output logic                  d_rsp_valid,
   output logic [DATA_WIDTH-1:0] d_rsp_data,
   input  logic                  d_rsp_ready,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   state_t                state, state_nx;
   logic                  grant, grant_nx;          // 1 = D owns the current access
   logic [CW-1:0]         starve_cnt, starve_nx;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic [DATA_WIDTH-1:0] f_data_nx, d_data_nx;
   logic                  d_win;
   logic                  at_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         starve_cnt <= '0;
         rom_addr   <= '0;
         f_rsp_data <= '0;
         d_rsp_data <= '0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         starve_cnt <= starve_nx;
         rom_addr   <= addr_nx;
         f_rsp_data <= f_data_nx;
         d_rsp_data <= d_data_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      grant_nx    = grant;
      starve_nx   = starve_cnt;
      addr_nx     = rom_addr;
      f_data_nx   = f_rsp_data;
      d_data_nx   = d_rsp_data;
      f_req_ready = 1'b0;
      d_req_ready = 1'b0;
      at_limit    = (starve_cnt == CW'(STARVE_LIMIT));
      d_win       = d_req_valid && (!f_req_valid || at_limit);

      case (state)
         IDLE: begin
            if (d_win) begin
               d_req_ready = 1'b1;
               addr_nx     = d_req_addr;
               grant_nx    = 1'b1;
               starve_nx   = '0;
               state_nx    = READ;
            end else if (f_req_valid) begin
               f_req_ready = 1'b1;
               addr_nx     = f_req_addr;
               grant_nx    = 1'b0;
               // Count F grants that bypass a waiting D; saturate at the limit
               if (!d_req_valid)
                  starve_nx = '0;
               else if (!at_limit)
                  starve_nx = starve_cnt + CW'(1);
               state_nx    = READ;
            end
         end
         READ: begin
            if (grant) d_data_nx = rom_q;
            else       f_data_nx = rom_q;
            state_nx = RESP;
         end
         RESP: begin
            if (grant ? d_rsp_ready : f_rsp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign f_rsp_valid = (state == RESP) && !grant;
   assign d_rsp_valid = (state == RESP) &&  grant;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a behavioural ROM and hand-computed expectations.
module tb_rom_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
   logic [9:0]  f_req_addr;
   logic [31:0] f_rsp_data;
   logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
   logic [9:0]  d_req_addr;
   logic [31:0] d_rsp_data;
   logic [9:0]  rom_addr;
   logic [31:0] rom_q;
   logic        busy;

   logic [31:0] rom [0:1023];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;
   assign rom_q = rom[rom_addr];

   rom_fetch_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
      .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_ready(f_rsp_ready),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_ready(d_rsp_ready),
      .rom_addr(rom_addr), .rom_q(rom_q), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] f_hold;
   logic [9:0]  exp_d;

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'hA5A5_0000 | 32'(i);
      rom[3]  = 32'h0000_0013;
      rom[5]  = 32'hDEAD_BEEF;
      rom[9]  = 32'h0000_0999;
      rom[20] = 32'h1234_0020;
      rom[30] = 32'hCAFE_0030;

      rst = 1'b1;
      f_req_valid = 0; f_req_addr = '0; f_rsp_ready = 0;
      d_req_valid = 0; d_req_addr = '0; d_rsp_ready = 0;
      tick; tick;
      rst = 1'b0;
      tick;
      chk("reset_busy", 64'(busy), 0);
      chk("reset_rom_addr", 64'(rom_addr), 0);
      chk("reset_f_rsp_valid", 64'(f_rsp_valid), 0);
      chk("reset_d_rsp_data", 64'(d_rsp_data), 0);

      // Fetch of addr 5: ready in the request cycle, response two edges later
      f_req_valid = 1; f_req_addr = 10'd5;
      #1;
      chk("f_ready_at_T", 64'(f_req_ready), 1);
      chk("d_ready_at_T", 64'(d_req_ready), 0);
      tick;
      f_req_valid = 0; f_req_addr = 10'd77;
      chk("rom_addr_latched", 64'(rom_addr), 5);
      chk("f_ready_in_read", 64'(f_req_ready), 0);
      chk("f_valid_early", 64'(f_rsp_valid), 0);
      tick;
      chk("f_valid_T2", 64'(f_rsp_valid), 1);
      chk("f_data_T2", 64'(f_rsp_data), 64'h0000_0000_DEAD_BEEF);
      chk("d_valid_during_f", 64'(d_rsp_valid), 0);

      // Backpressure: hold 3 cycles with D waiting
      d_req_valid = 1; d_req_addr = 10'd7;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("stall_f_valid", 64'(f_rsp_valid), 1);
         chk("stall_f_data", 64'(f_rsp_data), 64'h0000_0000_DEAD_BEEF);
         chk("stall_d_ready", 64'(d_req_ready), 0);
      end
      f_rsp_ready = 1;
      tick;
      chk("release_busy", 64'(busy), 0);
      chk("release_f_valid", 64'(f_rsp_valid), 0);
      d_req_valid = 0;
      f_rsp_ready = 0;

      // Async reset mid-cycle while a fetch response is held
      f_req_valid = 1; f_req_addr = 10'd5;
      tick; f_req_valid = 0;
      tick;
      chk("pre_rst_f_valid", 64'(f_rsp_valid), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_f_valid", 64'(f_rsp_valid), 0);
      chk("async_f_data", 64'(f_rsp_data), 0);
      chk("async_rom_addr", 64'(rom_addr), 0);
      chk("async_busy", 64'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      chk("post_rst_busy", 64'(busy), 0);

      // Reset during READ of a D access to addr 9
      d_req_valid = 1; d_req_addr = 10'd9; d_rsp_ready = 1;
      tick; d_req_valid = 0;
      chk("d9_read_busy", 64'(busy), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("d9_rst_rom_addr", 64'(rom_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("d9_dropped_valid", 64'(d_rsp_valid), 0);
      end
      d_req_valid = 1; d_req_addr = 10'd9;
      #1;
      chk("d9_retry_ready", 64'(d_req_ready), 1);
      tick; d_req_valid = 0;
      tick;
      chk("d9_retry_valid", 64'(d_rsp_valid), 1);
      chk("d9_retry_data", 64'(d_rsp_data), 64'h0000_0999);
      tick;

      // Only D valid, addr 3
      d_req_valid = 1; d_req_addr = 10'd3;
      #1;
      chk("d3_ready", 64'(d_req_ready), 1);
      chk("d3_f_ready", 64'(f_req_ready), 0);
      tick; d_req_valid = 0;
      tick;
      chk("d3_valid", 64'(d_rsp_valid), 1);
      chk("d3_data", 64'(d_rsp_data), 64'h13);
      chk("d3_f_valid", 64'(f_rsp_valid), 0);
      chk("d3_starve", 64'(dut.starve_cnt), 0);
      tick;

      // Starvation: both valid continuously -> F,F,F,F,D,F,F,F,F,D
      exp_d = 10'b10_0001_0000;
      f_req_valid = 1; f_req_addr = 10'd20; f_rsp_ready = 1;
      d_req_valid = 1; d_req_addr = 10'd30; d_rsp_ready = 1;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("starve_d_ready", 64'(d_req_ready), 64'(exp_d[i]));
         chk("starve_f_ready", 64'(f_req_ready), 64'(!exp_d[i]));
         tick; tick;
         if (exp_d[i]) chk("starve_d_data", 64'(d_rsp_data), 64'hCAFE_0030);
         else          chk("starve_f_data", 64'(f_rsp_data), 64'h1234_0020);
         f_hold = 32'(f_rsp_valid);
         chk("starve_f_valid", 64'(f_hold), 64'(!exp_d[i]));
         tick;
      end
      f_req_valid = 0; d_req_valid = 0;
      tick;
      chk("end_busy", 64'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
